// File: rtl/ofmap_packer.sv
// rtl/ofmap_packer.sv - repacks 64/64/48/64-bit row segments into a 64-bit DRAM word stream
module ofmap_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] segIn,
  input  logic        segValid,
  output logic        segReady,
  output logic [1:0]  segAddress,
  output logic [63:0] dramOut,
  output logic        dramValid,
  input  logic        dramReady,
  output logic [4:0]  rowCount,
  output logic        frameDone
);

  logic [127:0] buffer, buffer_nxt, shifted, seg_mask, seg_data;
  logic [7:0]   index, index_nxt, base, width;
  logic [5:0]   wordCount;
  logic         push, pop;

  assign segReady  = (index <= 8'd64);
  assign dramValid = (index >= 8'd64);
  assign dramOut   = buffer[63:0];
  assign push      = segValid & segReady;
  assign pop       = dramValid & dramReady;

  // Pop shifts first, so a same-cycle push lands just above the surviving bits.
  always_comb begin
    width      = (segAddress == 2'd2) ? 8'd48 : 8'd64;
    seg_mask   = (segAddress == 2'd2) ? {80'd0, {48{1'b1}}} : {64'd0, {64{1'b1}}};
    seg_data   = {64'd0, segIn} & seg_mask;
    base       = pop ? (index - 8'd64) : index;
    shifted    = pop ? {64'd0, buffer[127:64]} : buffer;
    buffer_nxt = shifted;
    index_nxt  = base;
    if (push) begin
      buffer_nxt = (shifted & ~(seg_mask << base)) | (seg_data << base);
      index_nxt  = base + width;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buffer     <= '0;
      index      <= '0;
      segAddress <= '0;
      rowCount   <= '0;
      wordCount  <= '0;
      frameDone  <= 1'b0;
    end else begin
      buffer    <= buffer_nxt;
      index     <= index_nxt;
      frameDone <= pop && (wordCount == 6'd59);
      if (push) begin
        segAddress <= segAddress + 2'd1;
        if (segAddress == 2'd3)
          rowCount <= (rowCount == 5'd15) ? 5'd0 : rowCount + 5'd1;
      end
      if (pop)
        wordCount <= (wordCount == 6'd59) ? 6'd0 : wordCount + 6'd1;
    end
  end

endmodule

// File: tb/tb_ofmap_packer.sv
// tb/tb_ofmap_packer.sv - directed self-checking bench for ofmap_packer
module tb_ofmap_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] segIn;
  logic        segValid;
  logic        segReady;
  logic [1:0]  segAddress;
  logic [63:0] dramOut;
  logic        dramValid;
  logic        dramReady;
  logic [4:0]  rowCount;
  logic        frameDone;

  int passed = 0;
  int total  = 0;
  logic [63:0] words[$];

  localparam logic [63:0] SEG0 = 64'h0706050403020100;
  localparam logic [63:0] SEG1 = 64'h0F0E0D0C0B0A0908;
  localparam logic [63:0] SEG2 = 64'hFFFF151413121110;
  localparam logic [63:0] SEG3 = 64'h1D1C1B1A19181716;

  always #5 clk = ~clk;

  ofmap_packer dut (
    .clk(clk), .rst(rst), .segIn(segIn), .segValid(segValid), .segReady(segReady),
    .segAddress(segAddress), .dramOut(dramOut), .dramValid(dramValid),
    .dramReady(dramReady), .rowCount(rowCount), .frameDone(frameDone)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    if (dramValid && dramReady) words.push_back(dramOut);
    @(posedge clk);
    #1;
  endtask

  task automatic push_seg(input logic [63:0] d);
    segIn    = d;
    segValid = 1'b1;
    step();
    segValid = 1'b0;
  endtask

  task automatic do_reset();
    segValid = 1'b0;
    segIn    = '0;
    #2 rst = 1'b0;
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    words.delete();
  endtask

  function automatic logic [63:0] exp_word(input int n);
    logic [63:0] w;
    for (int j = 0; j < 8; j++) w[8*j +: 8] = 8'((8*n + j) & 255);
    return w;
  endfunction

  // Row r holds bytes r*30 .. r*30+29; the 48-bit slot carries junk in its top bytes.
  function automatic logic [63:0] seg_word(input int row, input int s);
    logic [63:0] w;
    int off, nb;
    off = (s == 0) ? 0 : (s == 1) ? 8 : (s == 2) ? 16 : 22;
    nb  = (s == 2) ? 6 : 8;
    for (int j = 0; j < 8; j++)
      w[8*j +: 8] = (j < nb) ? 8'((row*30 + off + j) & 255) : 8'hFF;
    return w;
  endfunction

  initial begin
    int seg_i, nwords, bad, fd_count, fd_iter, pop60_iter;
    logic p_push, p_pop;

    rst = 1'b0; segValid = 1'b0; segIn = '0; dramReady = 1'b0;
    #3;
    check("rst_segReady", segReady, 1'b1);
    check("rst_dramValid", dramValid, 1'b0);
    check("rst_dramOut", dramOut, 64'h0);
    check("rst_segAddress", segAddress, 2'd0);
    check("rst_rowCount", rowCount, 5'd0);
    check("rst_frameDone", frameDone, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Single row, DRAM always ready
    dramReady = 1'b1;
    push_seg(SEG0);
    check("t1_first_valid", dramValid, 1'b1);
    push_seg(SEG1);
    check("t1_pushpop_index", dut.index, 8'd64);
    check("t1_pushpop_ready", segReady, 1'b1);
    check("t1_pushpop_out", dramOut, SEG1);
    push_seg(SEG2);
    push_seg(SEG3);
    step();
    check("t1_nwords", words.size(), 3);
    check("t1_w0", words[0], 64'h0706050403020100);
    check("t1_w1", words[1], 64'h0F0E0D0C0B0A0908);
    check("t1_w2", words[2], 64'h1716151413121110);
    check("t1_index", dut.index, 8'd48);
    check("t1_buffer", dut.buffer[47:0], 48'h1D1C1B1A1918);
    check("t1_rowCount", rowCount, 5'd1);
    check("t1_segAddress", segAddress, 2'd0);

    // Backpressure
    do_reset();
    dramReady = 1'b0;
    push_seg(SEG0);
    push_seg(SEG1);
    check("t2_index_full", dut.index, 8'd128);
    check("t2_segReady", segReady, 1'b0);
    check("t2_hold_out", dramOut, SEG0);
    push_seg(SEG2);
    check("t2_ignored_index", dut.index, 8'd128);
    check("t2_ignored_addr", segAddress, 2'd2);
    check("t2_still_out", dramOut, SEG0);
    dramReady = 1'b1;
    step();
    check("t2_drain1_out", dramOut, SEG1);
    check("t2_drain1_index", dut.index, 8'd64);
    step();
    check("t2_drain_empty", dramValid, 1'b0);
    check("t2_drain_n", words.size(), 2);
    check("t2_drain_w0", words[0], SEG0);
    check("t2_drain_w1", words[1], SEG1);
    check("t2_wordCount", dut.wordCount, 6'd2);

    // Async reset mid-row
    do_reset();
    dramReady = 1'b1;
    push_seg(SEG0);
    push_seg(SEG1);
    push_seg(SEG2);
    check("t3_pre_addr", segAddress, 2'd3);
    #2 rst = 1'b0;
    #1;
    check("t3_async_addr", segAddress, 2'd0);
    check("t3_async_valid", dramValid, 1'b0);
    check("t3_async_ready", segReady, 1'b1);
    check("t3_async_index", dut.index, 8'd0);
    check("t3_async_wc", dut.wordCount, 6'd0);
    check("t3_async_buf", dut.buffer, 128'h0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    push_seg(64'hA5A5_5A5A_C3C3_3C3C);
    check("t3_resume_index", dut.index, 8'd64);
    check("t3_resume_out", dramOut, 64'hA5A5_5A5A_C3C3_3C3C);
    check("t3_resume_addr", segAddress, 2'd1);

    // Full frame with random backpressure
    do_reset();
    seg_i = 0; nwords = 0; bad = 0; fd_count = 0; fd_iter = -1; pop60_iter = -100;
    for (int it = 0; it < 3000; it++) begin
      if (nwords >= 60 && it > pop60_iter + 4) break;
      segValid  = (seg_i < 64);
      segIn     = (seg_i < 64) ? seg_word(seg_i / 4, seg_i % 4) : 64'h0;
      dramReady = ($urandom_range(0, 3) != 0);
      p_push = segValid && segReady;
      p_pop  = dramValid && dramReady;
      if (p_pop) begin
        if (dramOut !== exp_word(nwords)) bad++;
        nwords++;
        if (nwords == 60) pop60_iter = it;
      end
      if (p_push) seg_i++;
      @(posedge clk);
      #1;
      if (frameDone) begin
        fd_count++;
        fd_iter = it;
      end
    end
    segValid = 1'b0;
    check("t4_segs", seg_i, 64);
    check("t4_nwords", nwords, 60);
    check("t4_bad_words", bad, 0);
    check("t4_fd_count", fd_count, 1);
    check("t4_fd_timing", fd_iter, pop60_iter);
    check("t4_rowCount", rowCount, 5'd0);
    check("t4_segAddress", segAddress, 2'd0);
    check("t4_wordCount", dut.wordCount, 6'd0);
    check("t4_index", dut.index, 8'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
